grid_cell_renderer: RTL and testbench

Parametrised successor to the grid address counter and position/pixel mapping blocks. Walks a GRID_W x GRID_H board held in BRAM, in row-major order or for one selected cell. For each cell it reads the BRAM word and emits every pixel of the CELL_W x CELL_W tile through a valid/ready stream. Sits between the board BRAM and the VGA plotter.

---
 rtl/grid_pkg.sv | 31 +++
 rtl/cell_raster_counter.sv | 50 +++++
 rtl/grid_cell_renderer.sv | 159 +++++++++++++++
 tb/tb_grid_cell_renderer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants, state encoding and geometry check for the grid renderer
package grid_pkg;

    localparam int GRID_W    = 16;
    localparam int GRID_H    = 16;
    localparam int CELL_W    = 10;
    localparam int SPACING   = 2;
    localparam int PITCH     = CELL_W + SPACING;
    localparam int NUM_CELLS = GRID_W * GRID_H;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DRAW,
        ST_NEXT,
        ST_FIN
    } state_t;

    // True when the far corner of the last tile still fits in the pixel buses.
    function automatic bit pixel_widths_ok(input int gw, input int gh, input int cw, input int sp,
                                           input int org_x, input int org_y,
                                           input int xw, input int yw);
        longint max_x;
        longint max_y;
        max_x = longint'(org_x) + longint'(gw - 1) * longint'(cw + sp) + longint'(cw - 1);
        max_y = longint'(org_y) + longint'(gh - 1) * longint'(cw + sp) + longint'(cw - 1);
        return (max_x < (longint'(1) << xw)) && (max_y < (longint'(1) << yw));
    endfunction

endpackage

// File: rtl/cell_raster_counter.sv
// rtl/cell_raster_counter.sv - ox/oy tile raster counters, ox inner loop, oy outer loop
module cell_raster_counter #(
    parameter int CELL_W = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      advance,
    output logic [$clog2(CELL_W)-1:0] ox,
    output logic [$clog2(CELL_W)-1:0] oy,
    output logic                      last_pixel
);

    localparam int OW = $clog2(CELL_W);
    localparam logic [OW-1:0] LAST = OW'(CELL_W - 1);

    logic [OW-1:0] ox_q, ox_d;
    logic [OW-1:0] oy_q, oy_d;

    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        if (clear) begin
            ox_d = '0;
            oy_d = '0;
        end else if (advance) begin
            if (ox_q == LAST) begin
                ox_d = '0;
                oy_d = (oy_q == LAST) ? '0 : oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    assign ox         = ox_q;
    assign oy         = oy_q;
    assign last_pixel = (ox_q == LAST) && (oy_q == LAST);

endmodule

// File: rtl/grid_cell_renderer.sv
// rtl/grid_cell_renderer.sv - walks the board BRAM and streams every tile pixel to the plotter
module grid_cell_renderer
    import grid_pkg::*;
#(
    parameter int GRID_W   = grid_pkg::GRID_W,
    parameter int GRID_H   = grid_pkg::GRID_H,
    parameter int CELL_W   = grid_pkg::CELL_W,
    parameter int SPACING  = grid_pkg::SPACING,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int ADDR_W   = 9,
    parameter int COLOR_W  = 3,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      single,
    input  logic [ADDR_W-1:0]         cell_sel,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rden,
    input  logic [COLOR_W-1:0]        mem_q,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [X_W-1:0]            pix_x,
    output logic [Y_W-1:0]            pix_y,
    output logic [COLOR_W-1:0]        pix_colour,
    output logic [$clog2(GRID_W)-1:0] pos_x,
    output logic [$clog2(GRID_H)-1:0] pos_y,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int PITCH     = CELL_W + SPACING;
    localparam int NUM_CELLS = GRID_W * GRID_H;
    localparam int PX_W      = $clog2(GRID_W);
    localparam int PY_W      = $clog2(GRID_H);
    localparam int OW        = $clog2(CELL_W);

    if (!pixel_widths_ok(GRID_W, GRID_H, CELL_W, SPACING, ORIGIN_X, ORIGIN_Y, X_W, Y_W)
        || ((longint'(1) << ADDR_W) < longint'(NUM_CELLS))) begin : g_bad_params
        $error("grid_cell_renderer: X_W/Y_W/ADDR_W too narrow for the grid geometry");
    end

    state_t               state_q, state_d;
    logic [PX_W-1:0]      pos_x_q, pos_x_d;
    logic [PY_W-1:0]      pos_y_q, pos_y_d;
    logic                 single_q, single_d;
    logic                 err_q, err_d;
    logic [COLOR_W-1:0]   colour_q, colour_d;
    logic [OW-1:0]        ox, oy;
    logic                 last_pixel;
    logic                 accept;
    logic [ADDR_W-1:0]    cur_addr;

    assign cur_addr = ADDR_W'(int'(pos_y_q) * GRID_W + int'(pos_x_q));
    assign accept   = (state_q == ST_DRAW) && pix_ready;

    cell_raster_counter #(
        .CELL_W(CELL_W)
    ) u_raster (
        .clock     (clock),
        .reset     (reset),
        .clear     (state_q == ST_FETCH),
        .advance   (accept),
        .ox        (ox),
        .oy        (oy),
        .last_pixel(last_pixel)
    );

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        single_d = single_q;
        err_d    = err_q;
        colour_d = colour_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    single_d = single;
                    err_d    = 1'b0;
                    if (!single) begin
                        pos_x_d = '0;
                        pos_y_d = '0;
                        state_d = ST_FETCH;
                    end else if (int'(cell_sel) >= NUM_CELLS) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        pos_x_d = PX_W'(int'(cell_sel) % GRID_W);
                        pos_y_d = PY_W'(int'(cell_sel) / GRID_W);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                colour_d = mem_q;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                if (accept && last_pixel) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (single_q || (int'(cur_addr) == NUM_CELLS - 1)) begin
                    state_d = ST_FIN;
                end else begin
                    if (int'(pos_x_q) == GRID_W - 1) begin
                        pos_x_d = '0;
                        pos_y_d = pos_y_q + 1'b1;
                    end else begin
                        pos_x_d = pos_x_q + 1'b1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_FIN: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            single_q <= 1'b0;
            err_q    <= 1'b0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            single_q <= single_d;
            err_q    <= err_d;
            colour_q <= colour_d;
        end
    end

    // Pixel outputs derive from held counters, so they stay stable under backpressure.
    assign pix_valid  = (state_q == ST_DRAW);
    assign pix_x      = pix_valid ? X_W'(ORIGIN_X + int'(pos_x_q) * PITCH + int'(ox)) : '0;
    assign pix_y      = pix_valid ? Y_W'(ORIGIN_Y + int'(pos_y_q) * PITCH + int'(oy)) : '0;
    assign pix_colour = pix_valid ? colour_q : '0;
    assign mem_rden   = (state_q == ST_FETCH);
    assign mem_addr   = mem_rden ? cur_addr : '0;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done       = (state_q == ST_FIN);
    assign err        = (state_q == ST_FIN) && err_q;

endmodule

// File: tb/tb_grid_cell_renderer.sv
// tb/tb_grid_cell_renderer.sv - scoreboard bench for grid_cell_renderer
module tb_grid_cell_renderer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       single = 1'b0;
    logic [8:0] cell_sel = '0;
    logic [8:0] mem_addr;
    logic       mem_rden;
    logic [2:0] mem_q;
    logic       pix_valid;
    logic       pix_ready = 1'b1;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [2:0] pix_colour;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       busy;
    logic       done;
    logic       err;

    grid_cell_renderer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .single    (single),
        .cell_sel  (cell_sel),
        .mem_addr  (mem_addr),
        .mem_rden  (mem_rden),
        .mem_q     (mem_q),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_colour(pix_colour),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int force_col = -1;
    always @(posedge clock) begin
        if (reset) mem_q <= '0;
        else if (mem_rden) mem_q <= (force_col >= 0) ? force_col[2:0] : mem_addr[2:0];
    end

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } beat_t;

    beat_t      exp_q[$];
    logic [8:0] addr_q[$];

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic push_cell(input int px, input int py, input int c);
        for (int oy = 0; oy < 10; oy++)
            for (int ox = 0; ox < 10; ox++)
                exp_q.push_back('{x: 10'(px * 12 + ox), y: 9'(py * 12 + oy), c: 3'(c)});
    endtask

    int         beats_total = 0, rden_total = 0, done_total = 0, p50_cycles = 0;
    int         done_cyc = 0;
    logic       done_err = 1'b0;
    logic [9:0] last_x = '0;
    logic [8:0] last_y = '0;
    logic [2:0] last_c = '0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    beat_t      prev_beat;

    always @(negedge clock) begin
        beat_t e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready && pix_valid) begin
                vectors++;
                if ({pix_x, pix_y, pix_colour} != prev_beat) begin
                    miscompares++;
                    $display("FAIL hold: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                             pix_x, pix_y, pix_colour, prev_beat.x, prev_beat.y, prev_beat.c);
                end
            end
            if (pix_valid && pix_x == 10'd5 && pix_y == 9'd0) p50_cycles++;
            if (pix_valid && pix_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: got (%0d,%0d,c%0d), expected none",
                             pix_x, pix_y, pix_colour);
                end else begin
                    e = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_colour} != e) begin
                        miscompares++;
                        $display("FAIL beat: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                                 pix_x, pix_y, pix_colour, e.x, e.y, e.c);
                    end
                end
                beats_total++;
                last_x = pix_x;
                last_y = pix_y;
                last_c = pix_colour;
            end
            if (mem_rden) begin
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rden_unexpected: got addr %0d, expected no read", mem_addr);
                end else if (mem_addr != addr_q[0]) begin
                    miscompares++;
                    $display("FAIL mem_addr: got %0d, expected %0d", mem_addr, addr_q[0]);
                    void'(addr_q.pop_front());
                end else begin
                    void'(addr_q.pop_front());
                end
                rden_total++;
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
                done_err = err;
            end
            prev_valid = pix_valid;
            prev_ready = pix_ready;
            prev_beat  = {pix_x, pix_y, pix_colour};
        end
    end

    int start_cyc = 0;

    task automatic start_job(input logic s, input logic [8:0] sel);
        @(posedge clock);
        #1;
        start     = 1'b1;
        single    = s;
        cell_sel  = sel;
        start_cyc = cyc;
        @(posedge clock);
        #1;
        start    = 1'b0;
        single   = 1'b0;
        cell_sel = '0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_total == base && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done_total == base) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        @(negedge clock);
        while (!pix_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!pix_valid) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int b_beats, b_rden, b_done, b_p50, n;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_valid", pix_valid, 0);
        chk("reset_rden", mem_rden, 0);
        chk("reset_pos", {pos_x, pos_y}, 0);

        // Single cell 17 -> tile at (12,12)..(21,21), colour 5
        force_col = 5;
        push_cell(1, 1, 5);
        addr_q.push_back(9'd17);
        b_beats = beats_total; b_rden = rden_total; b_done = done_total;
        start_job(1'b1, 9'd17);
        chk("t1_busy", busy, 1);
        wait_valid(10);
        chk("t1_first_x", pix_x, 12);
        chk("t1_first_y", pix_y, 12);
        chk("t1_pos_x", pos_x, 1);
        chk("t1_pos_y", pos_y, 1);
        wait_done(b_done, 300);
        chk("t1_latency", done_cyc - start_cyc + 1, 105);
        chk("t1_err", done_err, 0);
        chk("t1_last_x", last_x, 21);
        chk("t1_last_y", last_y, 21);
        chk("t1_beats", beats_total - b_beats, 100);
        chk("t1_rden", rden_total - b_rden, 1);
        chk("t1_left", exp_q.size(), 0);

        // Full frame, colour = address[2:0]
        force_col = -1;
        for (int a = 0; a < 256; a++) begin
            push_cell(a % 16, a / 16, a & 7);
            addr_q.push_back(9'(a));
        end
        b_beats = beats_total; b_rden = rden_total; b_done = done_total;
        start_job(1'b0, 9'd0);
        wait_done(b_done, 30000);
        chk("t2_latency", done_cyc - start_cyc + 1, 26370);
        chk("t2_last_x", last_x, 189);
        chk("t2_last_y", last_y, 189);
        chk("t2_last_c", last_c, 7);
        chk("t2_beats", beats_total - b_beats, 25600);
        chk("t2_rden", rden_total - b_rden, 256);
        chk("t2_addr_left", addr_q.size(), 0);

        // Single cell 0 with a 3-cycle stall on beat 5
        force_col = 6;
        push_cell(0, 0, 6);
        addr_q.push_back(9'd0);
        b_beats = beats_total; b_done = done_total; b_p50 = p50_cycles;
        start_job(1'b1, 9'd0);
        n = 0;
        while ((beats_total - b_beats) != 5 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("t3_reach_beat5", beats_total - b_beats, 5);
        pix_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 pix_ready = 1'b1;
        wait_done(b_done, 300);
        chk("t3_hold_cycles", p50_cycles - b_p50, 4);
        chk("t3_beats", beats_total - b_beats, 100);
        chk("t3_latency", done_cyc - start_cyc + 1, 108);

        // start retriggered with a different cell_sel mid-job
        force_col = 2;
        push_cell(1, 2, 2);
        addr_q.push_back(9'd33);
        b_rden = rden_total; b_done = done_total;
        start_job(1'b1, 9'd33);
        repeat (20) @(posedge clock);
        #1;
        start = 1'b1; single = 1'b1; cell_sel = 9'd99;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b0; single = 1'b0; cell_sel = '0;
        wait_done(b_done, 300);
        repeat (10) @(negedge clock);
        chk("t4_done_count", done_total - b_done, 1);
        chk("t4_rden", rden_total - b_rden, 1);
        chk("t4_left", exp_q.size(), 0);

        // Reset during DRAW of cell 40
        force_col = -1;
        for (int a = 0; a <= 40; a++) begin
            push_cell(a % 16, a / 16, a & 7);
            addr_q.push_back(9'(a));
        end
        b_rden = rden_total; b_done = done_total;
        start_job(1'b0, 9'd0);
        n = 0;
        while (!((rden_total - b_rden) == 41 && pix_valid) && n < 6000) begin
            @(negedge clock);
            n++;
        end
        chk("t5_reach_cell40", rden_total - b_rden, 41);
        repeat (10) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(negedge clock);
        chk("t5_busy", busy, 0);
        chk("t5_valid", pix_valid, 0);
        repeat (20) @(negedge clock);
        chk("t5_no_done", done_total - b_done, 0);
        push_cell(15, 15, 7);
        addr_q.push_back(9'd255);
        b_beats = beats_total; b_done = done_total;
        start_job(1'b1, 9'd255);
        wait_done(b_done, 300);
        chk("t5_restart_latency", done_cyc - start_cyc + 1, 105);
        chk("t5_restart_beats", beats_total - b_beats, 100);
        chk("t5_restart_last_x", last_x, 189);

        // Out-of-range single cell
        b_beats = beats_total; b_rden = rden_total; b_done = done_total;
        start_job(1'b1, 9'd300);
        wait_done(b_done, 20);
        chk("t6_done_cycle", done_cyc - start_cyc, 1);
        chk("t6_err", done_err, 1);
        repeat (5) @(negedge clock);
        chk("t6_rden", rden_total - b_rden, 0);
        chk("t6_beats", beats_total - b_beats, 0);
        chk("t6_done_count", done_total - b_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
